// File: rtl/fireball_projectile_control.sv
// Single-fireball controller: launch, per-frame horizontal motion, hit/edge
// termination, timed impact hold and launch cooldown.
module fireball_projectile_control #(
    parameter int X_MAX           = 639,
    parameter int FB_W            = 16,
    parameter int STEP            = 4,
    parameter int IMPACT_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       fire_req,
    input  logic [9:0] start_x,
    input  logic [9:0] start_y,
    input  logic       dir,
    input  logic       hit,
    output logic       is_active,
    output logic       impact,
    output logic       ready,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       hit_pulse,
    output logic [1:0] fsm_state
);

    localparam int MAX_FRAMES = (IMPACT_FRAMES > COOLDOWN_FRAMES) ? IMPACT_FRAMES : COOLDOWN_FRAMES;
    localparam int CW         = $clog2(MAX_FRAMES) + 1;

    localparam logic [10:0] RIGHT_LIMIT = 11'(X_MAX - FB_W + 1);
    localparam logic [10:0] STEP_W      = 11'(STEP);
    localparam logic [9:0]  STEP_N      = 10'(STEP);
    localparam logic [CW-1:0] IMPACT_LAST = CW'(IMPACT_FRAMES - 1);
    localparam logic [CW-1:0] COOL_LAST   = CW'(COOLDOWN_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        IMPACT   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [9:0]    x_nxt, y_nxt;
    logic          dir_q, dir_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          pulse_nxt;
    logic [10:0]   x_wide, x_plus;

    // Edge tests are done one bit wider so a step past 1023 or below 0 is caught, never wrapped.
    assign x_wide = {1'b0, pos_x};
    assign x_plus = x_wide + STEP_W;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            pos_x     <= '0;
            pos_y     <= '0;
            dir_q     <= 1'b0;
            cnt       <= '0;
            hit_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            pos_x     <= x_nxt;
            pos_y     <= y_nxt;
            dir_q     <= dir_nxt;
            cnt       <= cnt_nxt;
            hit_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = pos_x;
        y_nxt     = pos_y;
        dir_nxt   = dir_q;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (fire_req) begin
                    state_nxt = FLY;
                    x_nxt     = start_x;
                    y_nxt     = start_y;
                    dir_nxt   = dir;
                end
            end
            FLY: begin
                // A hit outranks a coincident frame tick: position freezes where it was struck.
                if (hit) begin
                    state_nxt = IMPACT;
                    pulse_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else if (frame_tick) begin
                    if (!dir_q) begin
                        if (x_plus > RIGHT_LIMIT) begin
                            state_nxt = COOLDOWN;
                            cnt_nxt   = '0;
                        end else begin
                            x_nxt = x_plus[9:0];
                        end
                    end else begin
                        if (x_wide < STEP_W) begin
                            state_nxt = COOLDOWN;
                            cnt_nxt   = '0;
                        end else begin
                            x_nxt = pos_x - STEP_N;
                        end
                    end
                end
            end
            IMPACT: begin
                if (frame_tick) begin
                    if (cnt == IMPACT_LAST) begin
                        state_nxt = COOLDOWN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    if (cnt == COOL_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign is_active = (state == FLY) || (state == IMPACT);
    assign impact    = (state == IMPACT);
    assign ready     = (state == IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_fireball_projectile_control.sv
// Bench for fireball_projectile_control: directed scenarios plus a randomized
// run compared cycle by cycle against a frame-counting reference model.
module tb_fireball_projectile_control;

    localparam int X_MAX = 639;
    localparam int FB_W  = 16;
    localparam int STEP  = 4;
    localparam int IMPF  = 8;
    localparam int COOLF = 30;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       fire_req = 1'b0;
    logic [9:0] start_x = '0;
    logic [9:0] start_y = '0;
    logic       dir = 1'b0;
    logic       hit = 1'b0;
    logic       is_active, impact, ready, hit_pulse;
    logic [9:0] pos_x, pos_y;
    logic [1:0] fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    fireball_projectile_control #(
        .X_MAX(X_MAX), .FB_W(FB_W), .STEP(STEP),
        .IMPACT_FRAMES(IMPF), .COOLDOWN_FRAMES(COOLF)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .fire_req(fire_req),
        .start_x(start_x), .start_y(start_y), .dir(dir), .hit(hit),
        .is_active(is_active), .impact(impact), .ready(ready),
        .pos_x(pos_x), .pos_y(pos_y), .hit_pulse(hit_pulse), .fsm_state(fsm_state)
    );

    always #5 Clk = ~Clk;

    // Reference model: phase 0 idle, 1 flying, 2 impact, 3 cooldown; frames_left counts down.
    int m_phase, m_x, m_y, m_dir, m_left, m_pulse;

    task automatic model_reset();
        m_phase = 0; m_x = 0; m_y = 0; m_dir = 0; m_left = 0; m_pulse = 0;
    endtask

    task automatic model_update();
        m_pulse = 0;
        case (m_phase)
            0: if (fire_req) begin
                m_phase = 1; m_x = int'(start_x); m_y = int'(start_y); m_dir = int'(dir);
            end
            1: if (hit) begin
                m_phase = 2; m_left = IMPF; m_pulse = 1;
            end else if (frame_tick) begin
                if (m_dir == 0) begin
                    if (m_x + STEP > X_MAX - FB_W + 1) begin m_phase = 3; m_left = COOLF; end
                    else m_x = m_x + STEP;
                end else begin
                    if (m_x < STEP) begin m_phase = 3; m_left = COOLF; end
                    else m_x = m_x - STEP;
                end
            end
            2: if (frame_tick) begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_phase = 3; m_left = COOLF; end
            end
            default: if (frame_tick) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic step();
        @(posedge Clk);
        if (Reset) model_update();
        @(negedge Clk);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    task automatic do_reset();
        fire_req = 0; frame_tick = 0; hit = 0; dir = 0; start_x = 0; start_y = 0;
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic launch(input int x, input int y, input logic d);
        fire_req = 1'b1; start_x = 10'(x); start_y = 10'(y); dir = d;
        step();
        fire_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({ready, is_active, impact, hit_pulse} !== 4'b1000) begin
            n_bad++; $display("FAIL reset_flags got %b want 1000", {ready, is_active, impact, hit_pulse});
        end
        n_cmp++;
        if (pos_x !== 10'd0 || pos_y !== 10'd0) begin
            n_bad++; $display("FAIL reset_pos got %0d,%0d want 0,0", pos_x, pos_y);
        end
    endtask

    task automatic test_launch();
        do_reset();
        launch(100, 200, 1'b0);
        n_cmp++;
        if ({is_active, ready} !== 2'b10 || pos_x !== 10'd100 || pos_y !== 10'd200) begin
            n_bad++; $display("FAIL launch got act=%b rdy=%b x=%0d y=%0d want 1 0 100 200", is_active, ready, pos_x, pos_y);
        end
        tick_n(3);
        n_cmp++;
        if (pos_x !== 10'd112) begin
            n_bad++; $display("FAIL launch_move pos_x got %0d want 112", pos_x);
        end
    endtask

    task automatic test_right_edge();
        logic saw_impact;
        int want [3];
        saw_impact = 1'b0;
        want[0] = 620; want[1] = 624; want[2] = 624;
        do_reset();
        launch(616, 50, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick_n(1);
            if (impact) saw_impact = 1'b1;
            n_cmp++;
            if (pos_x !== 10'(want[i])) begin
                n_bad++; $display("FAIL right_edge tick%0d pos_x got %0d want %0d", i + 1, pos_x, want[i]);
            end
        end
        n_cmp++;
        if (is_active !== 1'b0 || ready !== 1'b0) begin
            n_bad++; $display("FAIL right_edge_stop got act=%b rdy=%b want 0 0", is_active, ready);
        end
        for (int i = 0; i < COOLF - 1; i++) begin
            tick_n(1);
            if (impact) saw_impact = 1'b1;
        end
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++; $display("FAIL right_edge_cool29 ready got %b want 0", ready);
        end
        tick_n(1);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++; $display("FAIL right_edge_cool30 ready got %b want 1", ready);
        end
        n_cmp++;
        if (saw_impact !== 1'b0) begin
            n_bad++; $display("FAIL right_edge_impact got %b want 0", saw_impact);
        end
    endtask

    task automatic test_left_edge();
        do_reset();
        launch(6, 77, 1'b1);
        tick_n(1);
        n_cmp++;
        if (pos_x !== 10'd2) begin
            n_bad++; $display("FAIL left_edge tick1 pos_x got %0d want 2", pos_x);
        end
        tick_n(1);
        n_cmp++;
        if (pos_x !== 10'd2 || is_active !== 1'b0 || ready !== 1'b0) begin
            n_bad++; $display("FAIL left_edge tick2 got x=%0d act=%b rdy=%b want 2 0 0", pos_x, is_active, ready);
        end
    endtask

    task automatic test_hit_with_tick();
        do_reset();
        launch(300, 120, 1'b0);
        hit = 1'b1; frame_tick = 1'b1;
        step();
        hit = 1'b0; frame_tick = 1'b0;
        n_cmp++;
        if (pos_x !== 10'd300 || impact !== 1'b1 || hit_pulse !== 1'b1) begin
            n_bad++; $display("FAIL hit_tick got x=%0d imp=%b pulse=%b want 300 1 1", pos_x, impact, hit_pulse);
        end
        step();
        n_cmp++;
        if (hit_pulse !== 1'b0 || impact !== 1'b1) begin
            n_bad++; $display("FAIL hit_pulse_width got pulse=%b imp=%b want 0 1", hit_pulse, impact);
        end
        tick_n(IMPF - 1);
        n_cmp++;
        if (is_active !== 1'b1) begin
            n_bad++; $display("FAIL impact_7 is_active got %b want 1", is_active);
        end
        tick_n(1);
        n_cmp++;
        if (is_active !== 1'b0 || impact !== 1'b0) begin
            n_bad++; $display("FAIL impact_8 got act=%b imp=%b want 0 0", is_active, impact);
        end
        tick_n(COOLF - 1);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++; $display("FAIL hit_cool29 ready got %b want 0", ready);
        end
        tick_n(1);
        n_cmp++;
        if (ready !== 1'b1 || pos_x !== 10'd300) begin
            n_bad++; $display("FAIL hit_cool30 got rdy=%b x=%0d want 1 300", ready, pos_x);
        end
    endtask

    task automatic test_fire_ignored();
        do_reset();
        launch(50, 10, 1'b0);
        launch(500, 400, 1'b1);
        n_cmp++;
        if (pos_x !== 10'd50 || pos_y !== 10'd10 || is_active !== 1'b1) begin
            n_bad++; $display("FAIL fire_in_fly got x=%0d y=%0d act=%b want 50 10 1", pos_x, pos_y, is_active);
        end
        tick_n(1);
        n_cmp++;
        if (pos_x !== 10'd54) begin
            n_bad++; $display("FAIL fire_in_fly_dir pos_x got %0d want 54", pos_x);
        end
        hit = 1'b1; step(); hit = 1'b0;
        launch(500, 400, 1'b1);
        n_cmp++;
        if (impact !== 1'b1 || pos_x !== 10'd54) begin
            n_bad++; $display("FAIL fire_in_impact got imp=%b x=%0d want 1 54", impact, pos_x);
        end
        tick_n(IMPF);
        launch(500, 400, 1'b1);
        n_cmp++;
        if (ready !== 1'b0 || is_active !== 1'b0 || pos_x !== 10'd54) begin
            n_bad++; $display("FAIL fire_in_cool got rdy=%b act=%b x=%0d want 0 0 54", ready, is_active, pos_x);
        end
        fire_req = 1'b1; start_x = 10'd200; start_y = 10'd33; dir = 1'b1;
        tick_n(COOLF - 1);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++; $display("FAIL held_fire_ready got %b want 1", ready);
        end
        step();
        fire_req = 1'b0;
        n_cmp++;
        if (ready !== 1'b0 || is_active !== 1'b1 || pos_x !== 10'd200 || pos_y !== 10'd33) begin
            n_bad++; $display("FAIL held_fire_relaunch got rdy=%b act=%b x=%0d y=%0d want 0 1 200 33", ready, is_active, pos_x, pos_y);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        launch(400, 300, 1'b0);
        tick_n(2);
        #2 Reset = 1'b0;
        #1;
        n_cmp++;
        if ({ready, is_active, impact, hit_pulse} !== 4'b1000 || pos_x !== 10'd0 || pos_y !== 10'd0) begin
            n_bad++; $display("FAIL async_reset got flags=%b x=%0d y=%0d want 1000 0 0", {ready, is_active, impact, hit_pulse}, pos_x, pos_y);
        end
        #1 Reset = 1'b1;
        model_reset();
        step();
        n_cmp++;
        if (ready !== 1'b1 || is_active !== 1'b0 || impact !== 1'b0) begin
            n_bad++; $display("FAIL async_release got rdy=%b act=%b imp=%b want 1 0 0", ready, is_active, impact);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            fire_req   = ($urandom_range(0, 7) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            hit        = ($urandom_range(0, 19) == 0);
            start_x    = 10'($urandom_range(0, 1023));
            start_y    = 10'($urandom_range(0, 1023));
            dir        = 1'($urandom_range(0, 1));
            step();
            n_cmp++;
            if (is_active !== (m_phase == 1 || m_phase == 2) || impact !== (m_phase == 2) ||
                ready !== (m_phase == 0) || hit_pulse !== 1'(m_pulse)) begin
                n_bad++;
                $display("FAIL random_flags cyc=%0d got act=%b imp=%b rdy=%b pulse=%b want phase=%0d pulse=%0d",
                         c, is_active, impact, ready, hit_pulse, m_phase, m_pulse);
            end
            n_cmp++;
            if (pos_x !== 10'(m_x) || pos_y !== 10'(m_y)) begin
                n_bad++; $display("FAIL random_pos cyc=%0d got %0d,%0d want %0d,%0d", c, pos_x, pos_y, m_x, m_y);
            end
        end
        fire_req = 0; frame_tick = 0; hit = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_launch();
        test_right_edge();
        test_left_edge();
        test_hit_with_tick();
        test_fire_ignored();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
